wb_arbiter: RTL and testbench

Writeback arbiter that drives the single register-file write port (we / rd_addr / rd_data) from two producers.
- Producer 1: the single-cycle ALU.
- Producer 2: the variable-latency load/store/multiply unit (LSU).
- LSU results are buffered in a small FIFO; the ALU has priority, bounded by an anti-starvation counter.
- Optional forwarding lookup lets the decode stage see values that have been accepted but not yet written to the register file.

---
 rtl/wb_arbiter_if.sv | 27 ++
 rtl/wb_arbiter.sv | 95 +++++++++
 tb/tb_wb_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: ALU/LSU request, register-file write and forwarding signals of the writeback arbiter
interface wb_arbiter_if #(parameter int LSU_DEPTH = 4);
  logic alu_valid, alu_ready;
  logic [4:0] alu_rd;
  logic [31:0] alu_data;
  logic lsu_valid, lsu_ready;
  logic [4:0] lsu_rd;
  logic [31:0] lsu_data;
  logic wb_we;
  logic [4:0] wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic [4:0] fwd_rs1_addr, fwd_rs2_addr;
  logic fwd_rs1_hit, fwd_rs2_hit;
  logic [31:0] fwd_rs1_data, fwd_rs2_data;
  logic [$clog2(LSU_DEPTH):0] fifo_count;
  logic busy;
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, fwd_rs1_addr, fwd_rs2_addr,
    input alu_ready, lsu_ready, wb_we, wb_rd_addr, wb_rd_data, fwd_rs1_hit, fwd_rs1_data,
    input fwd_rs2_hit, fwd_rs2_data, fifo_count, busy
  );
  modport slave (
    input alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, fwd_rs1_addr, fwd_rs2_addr,
    output alu_ready, lsu_ready, wb_we, wb_rd_addr, wb_rd_data, fwd_rs1_hit, fwd_rs1_data,
    output fwd_rs2_hit, fwd_rs2_data, fifo_count, busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: ALU-priority writeback arbiter with LSU FIFO, anti-starvation and optional forwarding (WB_FWD_EN)
module wb_arbiter #(
  parameter int LSU_DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic clk,
  input logic rst,
  wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(LSU_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0] FULL = LSU_DEPTH[AW:0];
  localparam logic [SW-1:0] LIMIT = STARVE_LIMIT[SW-1:0];
  logic [4:0] f_rd [LSU_DEPTH];
  logic [31:0] f_data [LSU_DEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0] cnt;
  logic [SW-1:0] sc;
  logic we_q;
  logic [4:0] addr_q;
  logic [31:0] data_q;
  logic empty, starve_block, alu_fire, push, pop;
  assign empty = cnt == '0;
  assign starve_block = sc == LIMIT && !empty;
  assign bus.alu_ready = !rst && !starve_block;
  assign bus.lsu_ready = !rst && cnt < FULL;
  assign alu_fire = bus.alu_valid && bus.alu_ready;
  assign pop = !alu_fire && !empty;
  assign push = bus.lsu_valid && bus.lsu_ready && bus.lsu_rd != 5'd0;
  assign bus.wb_we = we_q;
  assign bus.wb_rd_addr = addr_q;
  assign bus.wb_rd_data = data_q;
  assign bus.fifo_count = cnt;
  assign bus.busy = !empty || we_q;
  // LSU result FIFO: circular buffer, push and pop may happen in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rp <= '0;
      wp <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        f_rd[wp] <= bus.lsu_rd;
        f_data[wp] <= bus.lsu_data;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  // Registered output stage: ALU wins unless blocked, otherwise drain the FIFO head
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (alu_fire) begin
      we_q <= bus.alu_rd != 5'd0;
      addr_q <= bus.alu_rd;
      data_q <= bus.alu_data;
    end else if (pop) begin
      we_q <= 1'b1;
      addr_q <= f_rd[rp];
      data_q <= f_data[rp];
    end else begin
      we_q <= 1'b0;
    end
  end
  // Starve counter: counts ALU wins over a waiting FIFO head, saturating at the limit
  always_ff @(posedge clk) begin
    if (rst || empty || pop) sc <= '0;
    else if (alu_fire && sc != LIMIT) sc <= sc + 1'b1;
  end
`ifdef WB_FWD_EN
  function automatic logic [32:0] lookup(input logic [4:0] a);
    logic [32:0] r;
    logic [AW-1:0] idx;
    r = (we_q && addr_q == a) ? {1'b1, data_q} : 33'd0;
    for (int i = 0; i < LSU_DEPTH; i++) begin
      idx = rp + i[AW-1:0];
      if (i < int'(cnt) && f_rd[idx] == a) r = {1'b1, f_data[idx]};
    end
    return a == 5'd0 ? 33'd0 : r;
  endfunction
  assign {bus.fwd_rs1_hit, bus.fwd_rs1_data} = lookup(bus.fwd_rs1_addr);
  assign {bus.fwd_rs2_hit, bus.fwd_rs2_data} = lookup(bus.fwd_rs2_addr);
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.fwd_rs1_addr, bus.fwd_rs2_addr};
  assign bus.fwd_rs1_hit = 1'b0;
  assign bus.fwd_rs1_data = '0;
  assign bus.fwd_rs2_hit = 1'b0;
  assign bus.fwd_rs2_data = '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter (LSU_DEPTH=4, STARVE_LIMIT=8)
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  logic [36:0] alu_q[$];
  logic [36:0] lsu_q[$];
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  wb_arbiter_if #(.LSU_DEPTH(4)) bus();
  wb_arbiter #(.LSU_DEPTH(4), .STARVE_LIMIT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.alu_valid = 1'b0;
    bus.lsu_valid = 1'b0;
  endtask
  // LSU destinations used by this bench are 3, 7 and 20..31; everything else is ALU
  always @(negedge clk) begin : mon
    logic [36:0] w;
    if (bus.wb_we === 1'b1) begin
      w = {bus.wb_rd_addr, bus.wb_rd_data};
      chk("wb_addr_nonzero", 64'(bus.wb_rd_addr != 5'd0), 64'd1);
      if (w[36:32] == 5'd3 || w[36:32] == 5'd7 || w[36:32] >= 5'd20) begin
        if (lsu_q.size() > 0) chk("lsu_wb", 64'(w), 64'(lsu_q.pop_front()));
        else chk("lsu_wb_unexpected", 64'(lsu_q.size()), 64'd1);
      end else begin
        if (alu_q.size() > 0) chk("alu_wb", 64'(w), 64'(alu_q.pop_front()));
        else chk("alu_wb_unexpected", 64'(alu_q.size()), 64'd1);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    bus.fwd_rs1_addr = 0; bus.fwd_rs2_addr = 0;
    tick;
    tick;
    chk("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
    chk("rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
    chk("rst_we", 64'(bus.wb_we), 64'd0);
    chk("rst_addr", 64'(bus.wb_rd_addr), 64'd0);
    chk("rst_data", 64'(bus.wb_rd_data), 64'd0);
    chk("rst_count", 64'(bus.fifo_count), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_fwd1", 64'({bus.fwd_rs1_hit, bus.fwd_rs1_data}), 64'd0);
    rst = 1'b0;
    #1;
    chk("alu_ready_after_rst", 64'(bus.alu_ready), 64'd1);
    // single ALU write
    bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF;
    alu_q.push_back({5'd5, 32'hDEADBEEF});
    tick;
    idle;
    chk("t1_we", 64'(bus.wb_we), 64'd1);
    chk("t1_addr", 64'(bus.wb_rd_addr), 64'd5);
    chk("t1_data", 64'(bus.wb_rd_data), 64'hDEADBEEF);
    chk("t1_count", 64'(bus.fifo_count), 64'd0);
    tick;
    chk("t1_we_off", 64'(bus.wb_we), 64'd0);
    chk("t1_data_hold", 64'(bus.wb_rd_data), 64'hDEADBEEF);
    chk("t1_busy_off", 64'(bus.busy), 64'd0);
    // single LSU write, two-cycle latency
    chk("t2_lsu_ready", 64'(bus.lsu_ready), 64'd1);
    bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_data = 32'h12345678;
    lsu_q.push_back({5'd7, 32'h12345678});
    tick;
    idle;
    chk("t2_count1", 64'(bus.fifo_count), 64'd1);
    chk("t2_we_c1", 64'(bus.wb_we), 64'd0);
    chk("t2_busy_c1", 64'(bus.busy), 64'd1);
    tick;
    chk("t2_we_c2", 64'(bus.wb_we), 64'd1);
    chk("t2_addr", 64'(bus.wb_rd_addr), 64'd7);
    chk("t2_data", 64'(bus.wb_rd_data), 64'h12345678);
    chk("t2_count0", 64'(bus.fifo_count), 64'd0);
    tick;
    // FIFO fill under constant ALU pressure, then anti-starvation block
    for (int k = 0; k < 13; k++) begin
      bus.alu_valid = 1; bus.alu_rd = 5'(10 + k % 5); bus.alu_data = 32'hA0000000 + 32'(k);
      bus.lsu_valid = k < 4; bus.lsu_rd = 5'(20 + k); bus.lsu_data = 32'h50000000 + 32'(k);
      chk($sformatf("t3_alu_ready_%0d", k), 64'(bus.alu_ready), 64'(k != 9));
      chk($sformatf("t3_lsu_ready_%0d", k), 64'(bus.lsu_ready), 64'(k < 4 || k >= 10));
      if (k == 4) chk("t3_full_count", 64'(bus.fifo_count), 64'd4);
      if (bus.alu_ready) alu_q.push_back({bus.alu_rd, bus.alu_data});
      if (k < 4 && bus.lsu_ready) lsu_q.push_back({bus.lsu_rd, bus.lsu_data});
      tick;
      if (k == 9) begin
        chk("t3_block_we", 64'(bus.wb_we), 64'd1);
        chk("t3_block_addr", 64'(bus.wb_rd_addr), 64'd20);
        chk("t3_block_count", 64'(bus.fifo_count), 64'd3);
      end
    end
    idle;
    for (int i = 0; i < 20 && bus.busy; i++) tick;
    chk("t3_drained", 64'(bus.busy), 64'd0);
    // x0 requests from both producers are accepted but never written
    bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'h1111;
    bus.lsu_valid = 1; bus.lsu_rd = 0; bus.lsu_data = 32'h2222;
    chk("t4_alu_ready", 64'(bus.alu_ready), 64'd1);
    chk("t4_lsu_ready", 64'(bus.lsu_ready), 64'd1);
    tick;
    idle;
    chk("t4_we", 64'(bus.wb_we), 64'd0);
    chk("t4_count", 64'(bus.fifo_count), 64'd0);
    tick;
    chk("t4_we2", 64'(bus.wb_we), 64'd0);
    chk("t4_busy", 64'(bus.busy), 64'd0);
    // queued LSU entries are discarded by reset
    for (int k = 0; k < 3; k++) begin
      bus.alu_valid = 1; bus.alu_rd = 13; bus.alu_data = 32'hB0 + 32'(k);
      bus.lsu_valid = 1; bus.lsu_rd = 5'(21 + k); bus.lsu_data = 32'hE0 + 32'(k);
      chk($sformatf("t5_lsu_ready_%0d", k), 64'(bus.lsu_ready), 64'd1);
      alu_q.push_back({5'd13, bus.alu_data});
      tick;
    end
    idle;
    chk("t5_count3", 64'(bus.fifo_count), 64'd3);
    rst = 1'b1;
    #1;
    chk("t5_rst_alu_ready", 64'(bus.alu_ready), 64'd0);
    chk("t5_rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
    tick;
    rst = 1'b0;
    chk("t5_count0", 64'(bus.fifo_count), 64'd0);
    chk("t5_we", 64'(bus.wb_we), 64'd0);
    chk("t5_busy", 64'(bus.busy), 64'd0);
    for (int i = 0; i < 5; i++) tick;
    chk("t5_still_idle", 64'(bus.busy), 64'd0);
    // forwarding: youngest FIFO entry wins, x0 never hits, output stage hits
    for (int k = 0; k < 2; k++) begin
      bus.alu_valid = 1; bus.alu_rd = 12; bus.alu_data = 32'hC0 + 32'(k);
      bus.lsu_valid = 1; bus.lsu_rd = 3; bus.lsu_data = 32'(k + 1);
      alu_q.push_back({5'd12, bus.alu_data});
      lsu_q.push_back({5'd3, bus.lsu_data});
      tick;
    end
    idle;
    bus.fwd_rs1_addr = 3; bus.fwd_rs2_addr = 0;
    #1;
    chk("t6_count2", 64'(bus.fifo_count), 64'd2);
    chk("t6_rs1_hit", 64'(bus.fwd_rs1_hit), 64'(FWD));
    chk("t6_rs1_data", 64'(bus.fwd_rs1_data), FWD ? 64'h2 : 64'h0);
    chk("t6_rs2_hit_x0", 64'(bus.fwd_rs2_hit), 64'd0);
    chk("t6_rs2_data_x0", 64'(bus.fwd_rs2_data), 64'd0);
    bus.fwd_rs2_addr = 12;
    #1;
    chk("t6_rs2_hit_out", 64'(bus.fwd_rs2_hit), 64'(FWD));
    chk("t6_rs2_data_out", 64'(bus.fwd_rs2_data), FWD ? 64'hC1 : 64'h0);
    bus.fwd_rs1_addr = 0; bus.fwd_rs2_addr = 0;
    for (int i = 0; i < 20 && bus.busy; i++) tick;
    chk("t6_drained", 64'(bus.busy), 64'd0);
    tick;
    chk("alu_q_empty", 64'(alu_q.size()), 64'd0);
    chk("lsu_q_empty", 64'(lsu_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
